// File: rtl/pll_pkg.sv
// rtl/pll_pkg.sv - shared widths, default loop constants and saturating helpers for the digital PLL
package pll_pkg;

  localparam int CTRL_W = 24;

  localparam logic [CTRL_W-1:0] KP_DEFAULT        = 24'd4096;
  localparam logic [CTRL_W-1:0] KI_DEFAULT        = 24'd16;
  localparam logic [CTRL_W-1:0] INIT_WORD_DEFAULT = 24'h400000;

  function automatic logic [CTRL_W-1:0] sat_add(input logic [CTRL_W-1:0] a,
                                                input logic [CTRL_W-1:0] b);
    logic [CTRL_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CTRL_W] ? '1 : s[CTRL_W-1:0];
  endfunction

  function automatic logic [CTRL_W-1:0] sat_sub(input logic [CTRL_W-1:0] a,
                                                input logic [CTRL_W-1:0] b);
    return (a < b) ? '0 : (a - b);
  endfunction

endpackage

// File: rtl/pll_loop_filter.sv
// rtl/pll_loop_filter.sv - up/dn synchronizers, saturating integrator and speed_var register
// Proportional path enabled by PLL_PROP_PATH_EN; otherwise the loop is integral-only and KP is ignored.
module pll_loop_filter
  import pll_pkg::*;
#(
  parameter logic [CTRL_W-1:0] KP        = KP_DEFAULT,
  parameter logic [CTRL_W-1:0] KI        = KI_DEFAULT,
  parameter logic [CTRL_W-1:0] INIT_WORD = INIT_WORD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up,
  input  logic              dn,
  output logic [CTRL_W-1:0] speed_var
);

`ifdef PLL_PROP_PATH_EN
  localparam logic [CTRL_W-1:0] PROP_STEP = KP;
`else
  localparam logic [CTRL_W-1:0] PROP_STEP = KP & '0;
`endif

  logic              up_s1_q, up_s2_q, dn_s1_q, dn_s2_q;
  logic [CTRL_W-1:0] integ_q, integ_d, speed_q, speed_d;
  logic              up_only, dn_only;

  assign up_only = up_s2_q & ~dn_s2_q;
  assign dn_only = dn_s2_q & ~up_s2_q;

  always_comb begin
    integ_d = integ_q;
    speed_d = integ_q;
    if (up_only) begin
      integ_d = sat_add(integ_q, KI);
      speed_d = sat_add(integ_d, PROP_STEP);
    end else if (dn_only) begin
      integ_d = sat_sub(integ_q, KI);
      speed_d = sat_sub(integ_d, PROP_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      up_s1_q <= 1'b0;
      up_s2_q <= 1'b0;
      dn_s1_q <= 1'b0;
      dn_s2_q <= 1'b0;
      integ_q <= INIT_WORD;
      speed_q <= INIT_WORD;
    end else begin
      up_s1_q <= up;
      up_s2_q <= up_s1_q;
      dn_s1_q <= dn;
      dn_s2_q <= dn_s1_q;
      integ_q <= integ_d;
      speed_q <= speed_d;
    end
  end

  assign speed_var = speed_q;

endmodule

// File: rtl/digital_pll_core.sv
// rtl/digital_pll_core.sv - digital PLL: loop filter, modulo-(mod+1) phase-accumulator DCO and f_qn divider
// Optional proportional path selected by the PLL_PROP_PATH_EN macro (see pll_loop_filter).
module digital_pll_core
  import pll_pkg::*;
#(
  parameter logic [CTRL_W-1:0] KP        = KP_DEFAULT,
  parameter logic [CTRL_W-1:0] KI        = KI_DEFAULT,
  parameter logic [CTRL_W-1:0] INIT_WORD = INIT_WORD_DEFAULT,
  parameter int                DIV_N     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up,
  input  logic              dn,
  input  logic [CTRL_W-1:0] mod,
  output logic [CTRL_W-1:0] speed_var,
  output logic [CTRL_W-1:0] accum,
  output logic              signal_out,
  output logic              f_qn
);

  localparam logic [15:0] DIV_LAST = 16'(DIV_N / 2 - 1);

  logic [CTRL_W-1:0] accum_q, accum_d, inc;
  logic [CTRL_W:0]   sum, half;
  logic              so_q, so_d, so_prev_q, fqn_q, rise;
  logic [15:0]       div_cnt_q;

  pll_loop_filter #(.KP(KP), .KI(KI), .INIT_WORD(INIT_WORD)) u_loop_filter (
    .clk       (clk),
    .rst       (rst),
    .up        (up),
    .dn        (dn),
    .speed_var (speed_var)
  );

  // Result of sum - (mod+1) always fits in CTRL_W bits, so modular subtraction is exact.
  always_comb begin
    inc     = (speed_var < mod) ? speed_var : mod;
    sum     = {1'b0, accum_q} + {1'b0, inc};
    accum_d = (sum > {1'b0, mod}) ? (sum[CTRL_W-1:0] - mod - 24'd1) : sum[CTRL_W-1:0];
    half    = ({1'b0, mod} + 25'd1) >> 1;
    so_d    = (mod != '0) && ({1'b0, accum_d} >= half);
  end

  assign rise = so_q & ~so_prev_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      accum_q   <= '0;
      so_q      <= 1'b0;
      so_prev_q <= 1'b0;
      div_cnt_q <= '0;
      fqn_q     <= 1'b0;
    end else begin
      accum_q   <= accum_d;
      so_q      <= so_d;
      so_prev_q <= so_q;
      if (rise) begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_q <= '0;
          fqn_q     <= ~fqn_q;
        end else begin
          div_cnt_q <= div_cnt_q + 16'd1;
        end
      end
    end
  end

  assign accum      = accum_q;
  assign signal_out = so_q;
  assign f_qn       = fqn_q;

endmodule

// File: tb/tb_digital_pll_core.sv
// tb/tb_digital_pll_core.sv - directed self-checking bench for digital_pll_core (default and small-INIT_WORD instances)
module tb_digital_pll_core;

`ifdef PLL_PROP_PATH_EN
  localparam logic [23:0] KPX    = 24'd4096;
  localparam logic [23:0] FROZEN = 24'd60;
`else
  localparam logic [23:0] KPX    = 24'd0;
  localparam logic [23:0] FROZEN = 24'd64;
`endif
  localparam logic [0:11] FQ_TAB = 12'b001111000011;

  logic        clk = 1'b0;
  logic        rst;
  logic        up_a, dn_a, up_b, dn_b, up_c, dn_c;
  logic [23:0] mod_a, mod_b, mod_c;
  logic [23:0] spd_a, acc_a, spd_b, acc_b, spd_c, acc_c;
  logic        so_a, fq_a, so_b, fq_b, so_c, fq_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  digital_pll_core dut_a (
    .clk(clk), .rst(rst), .up(up_a), .dn(dn_a), .mod(mod_a),
    .speed_var(spd_a), .accum(acc_a), .signal_out(so_a), .f_qn(fq_a));

  digital_pll_core #(.INIT_WORD(24'd20)) dut_b (
    .clk(clk), .rst(rst), .up(up_b), .dn(dn_b), .mod(mod_b),
    .speed_var(spd_b), .accum(acc_b), .signal_out(so_b), .f_qn(fq_b));

  digital_pll_core #(.INIT_WORD(24'd300)) dut_c (
    .clk(clk), .rst(rst), .up(up_c), .dn(dn_c), .mod(mod_c),
    .speed_var(spd_c), .accum(acc_c), .signal_out(so_c), .f_qn(fq_c));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [23:0] ea, ec;

    rst = 1'b0;
    up_a = 0; dn_a = 0; up_b = 0; dn_b = 0; up_c = 0; dn_c = 0;
    mod_a = 24'hFFFFFF; mod_b = 24'hFFFFFF; mod_c = 24'd999;
    repeat (3) tick();
    check_eq("rst_speed", 32'(spd_a), 32'h400000);
    check_eq("rst_accum", 32'(acc_a), 32'h0);
    check_eq("rst_so", 32'(so_a), 32'h0);
    check_eq("rst_fqn", 32'(fq_a), 32'h0);
    check_eq("rst_accum_c", 32'(acc_c), 32'h0);

    // free run: 4-clk signal_out, 8-clk f_qn; dut_c counts modulo 1000
    rst = 1'b1;
    ea = 24'd0;
    ec = 24'd0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      ea = ea + 24'h400000;
      ec = ec + 24'd300;
      if (ec > 24'd999) ec = ec - 24'd1000;
      check_eq($sformatf("free_accum_%0d", i), 32'(acc_a), 32'(ea));
      check_eq($sformatf("free_so_%0d", i), 32'(so_a), 32'(ea >= 24'h800000));
      check_eq($sformatf("free_fqn_%0d", i), 32'(fq_a), 32'(FQ_TAB[i-1]));
      check_eq($sformatf("m999_accum_%0d", i), 32'(acc_c), 32'(ec));
      check_eq($sformatf("m999_so_%0d", i), 32'(so_c), 32'(ec >= 24'd500));
    end

    // up held 10 clk: two-flop latency then +KI per clk, plus KP while s2 up is high
    up_a = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 2)  check_eq("up_lat2", 32'(spd_a), 32'h400000);
      if (i == 3)  check_eq("up_first", 32'(spd_a), 32'(24'h400010 + KPX));
      if (i == 10) check_eq("up_10", 32'(spd_a), 32'(24'h400080 + KPX));
    end
    up_a = 1'b0;
    tick();
    check_eq("up_rel1", 32'(spd_a), 32'(24'h400090 + KPX));
    tick();
    check_eq("up_peak", 32'(spd_a), 32'(24'h4000A0 + KPX));
    tick();
    check_eq("up_settle", 32'(spd_a), 32'h4000A0);
    tick();
    check_eq("up_hold", 32'(spd_a), 32'h4000A0);

    // reset mid-ramp, then up=dn together, mod=0, dn saturation and live mod change
    rst = 1'b0;
    up_a = 1'b1; dn_a = 1'b1; mod_a = 24'd0; dn_b = 1'b1;
    tick();
    check_eq("rst2_speed", 32'(spd_a), 32'h400000);
    tick();
    rst = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 3) begin
        check_eq("modchg_pre", 32'(acc_c), 32'd900);
        mod_c = 24'd499;
      end
      if (i == 4) check_eq("modchg_wrap", 32'(acc_c), 32'd700);
      if (i == 5) check_eq("modchg_5", 32'(acc_c), 32'd500);
      if (i == 6) begin
        check_eq("modchg_6", 32'(acc_c), 32'd300);
        check_eq("dn_sat_speed", 32'(spd_b), 32'h0);
        check_eq("dn_freeze_6", 32'(acc_b), 32'(FROZEN));
      end
      if (i == 10) begin
        check_eq("both_speed_10", 32'(spd_a), 32'h400000);
        check_eq("mod0_accum", 32'(acc_a), 32'h0);
        check_eq("mod0_so", 32'(so_a), 32'h0);
      end
    end
    check_eq("both_speed_20", 32'(spd_a), 32'h400000);
    check_eq("dn_nowrap_speed", 32'(spd_b), 32'h0);
    check_eq("dn_freeze_20", 32'(acc_b), 32'(FROZEN));
    check_eq("mod0_so_20", 32'(so_a), 32'h0);
    check_eq("mod0_fqn_20", 32'(fq_a), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/digital_pll_core.md
DIGITAL_PLL_CORE -- requirements
Module: digital_pll_core

Interface
REQ-001 Parameter KP, default 24'd4096: proportional step added or subtracted while up or dn is active.
REQ-002 Parameter KI, default 24'd16: integrator step per clk while up or dn is active.
REQ-003 Parameter INIT_WORD, default 24'h400000: integrator and speed_var reset value, giving a 25 MHz signal_out from a 100 MHz clk.
REQ-004 Parameter DIV_N, default 2, even and >=2: signal_out rising edges per f_qn period.
REQ-005 clk  input  1  sole clock; every register updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-low reset.
REQ-007 up  input  1  phase-detector "speed up" request, asynchronous to clk.
REQ-008 dn  input  1  phase-detector "slow down" request, asynchronous to clk.
REQ-009 mod  input  24  accumulator modulus minus one; nominal value 24'hFFFFFF.
REQ-010 speed_var  output  24  registered DCO control word.
REQ-011 accum  output  24  registered phase accumulator.
REQ-012 signal_out  output  1  registered DCO output clock, a clk-synchronous level.
REQ-013 f_qn  output  1  registered divided feedback clock.

Function
REQ-014 up and dn each pass through a 2-flop synchronizer (s1, s2) before use.
REQ-015 Integrator (24-bit) per clk: s2 up only -> +KI; s2 dn only -> -KI; both or neither -> hold.
REQ-016 Integrator saturates: clamps at 24'hFFFFFF on overflow and at 0 on underflow, with no wrap.
REQ-017 speed_var <= integ_next, plus KP if s2 up only, minus KP if s2 dn only, saturated to [0, 24'hFFFFFF].
REQ-018 Latency: up sampled at edge k changes speed_var at edge k+2; release propagates with the same latency.
REQ-019 DCO increment inc = min(speed_var, mod), using the registered speed_var.
REQ-020 Accumulator sum = accum + inc in 25 bits; if sum > mod then accum <= sum - (mod+1), else accum <= sum.
REQ-021 mod = 0: accum stays 0 and signal_out stays 0.
REQ-022 signal_out <= 1 when the next accum value >= (mod+1)>>1, else 0.
REQ-023 For mod = 24'hFFFFFF, signal_out equals the MSB of the next accum value.
REQ-024 Divider: a rising edge is detected when signal_out = 1 and its previous registered value = 0.
REQ-025 Edge counter counts 0..DIV_N/2-1; f_qn toggles and the counter clears on the edge that reaches DIV_N/2-1.
REQ-026 f_qn frequency = signal_out frequency / DIV_N, with 50% duty in rising-edge counts.
REQ-027 A mod change mid-operation takes effect on the next clk with no accum reset; an accum value > new mod wraps via REQ-020.

Reset
REQ-028 While rst = 0 at a clk edge: sync flops = 0, integ = INIT_WORD, speed_var = INIT_WORD, accum = 0, signal_out = 0, signal_out history = 0, divider counter = 0, f_qn = 0.
REQ-029 Reset overrides all other updates, including mid-ramp or mid-divide; normal operation resumes on the first edge with rst = 1.

Configuration
REQ-030 Macro PLL_PROP_PATH_EN defined: proportional path per REQ-017.
REQ-031 PLL_PROP_PATH_EN undefined: speed_var <= integ_next (integral-only loop), and KP is ignored.

Structure
REQ-032 Package pll_pkg holds CTRL_W = 24 and the default constants for KP, KI and INIT_WORD.
REQ-033 One sub-module, pll_loop_filter, contains the synchronizers, integrator and speed_var register; the DCO and divider stay in the top level.

Verification
REQ-034 Reset: hold rst = 0 for 3 clk -> speed_var = 24'h400000, accum = 0, signal_out = 0, f_qn = 0.
REQ-035 Free run (up = dn = 0, mod = 24'hFFFFFF) -> accum = 0x400000, 0x800000, 0xC00000, 0, ...; signal_out period 4 clk (2 high, 2 low); f_qn period 8 clk.
REQ-036 Hold up = 1 for 10 clk (PLL_PROP_PATH_EN defined) -> speed_var reaches 24'h4010A0 during up and settles to 24'h4000A0 two clk after s2 drops.
REQ-037 Hold dn = 1 with INIT_WORD = 24'd20 -> speed_var saturates at 0 (no wrap) and accum freezes.
REQ-038 Hold up = dn = 1 for 20 clk -> speed_var remains 24'h400000.
REQ-039 mod = 999, INIT_WORD = 300 -> accum = 300, 600, 900, 200, 500, ...; signal_out = 1 exactly when accum >= 500.
